// File: rtl/ex_shad_pipe_if.sv
// Decode, shifter and writeback signals of the SHAD/SHLD execute pipeline.
// The slave modport is the pipeline's view; master is the surrounding core's.
interface ex_shad_pipe_if;
  logic        idValid;
  logic        idReady;
  logic [3:0]  idOp;
  logic [4:0]  idRn;
  logic [4:0]  idRm;
  logic [31:0] idValA;
  logic [31:0] idValB;
  logic [31:0] shValRs;
  logic [7:0]  shValRt;
  logic [2:0]  shOp;
  logic [31:0] shResult;
  logic        wbHold;
  logic        wbValid;
  logic [4:0]  wbRn;
  logic [31:0] wbVal;
  logic        wbSetT;
  logic        wbT;
  logic        wbIllegal;

  modport slave (
    input  idValid, idOp, idRn, idRm, idValA, idValB, shResult, wbHold,
    output idReady, shValRs, shValRt, shOp,
    output wbValid, wbRn, wbVal, wbSetT, wbT, wbIllegal
  );

  modport master (
    output idValid, idOp, idRn, idRm, idValA, idValB, shResult, wbHold,
    input  idReady, shValRs, shValRt, shOp,
    input  wbValid, wbRn, wbVal, wbSetT, wbT, wbIllegal
  );
endinterface

// File: rtl/ex_shad_pipe.sv
// Two-stage issue/writeback pipeline around the combinational SHAD/SHLD shifter,
// with operand bypass from both stages and T-bit generation for 1-bit shifts.
module ex_shad_pipe (
  input logic           clock,
  input logic           reset,
  ex_shad_pipe_if.slave bus
);

  logic        s1ValidReg;
  logic [3:0]  s1OpReg;
  logic [4:0]  s1RnReg;
  logic [31:0] s1AReg;
  logic [31:0] s1BReg;
  logic        s1TReg;

  logic        s2ValidReg;
  logic        s2WrReg;
  logic [4:0]  s2RnReg;
  logic [31:0] s2ValReg;
  logic        s2SetTReg;
  logic        s2TReg;
  logic        s2IllegalReg;

  logic        s1Wr;
  logic        s2Adv;
  logic        s1Adv;
  logic        tNext;
  logic [4:0]  srcIdx [2];
  logic [31:0] srcRf  [2];
  logic [31:0] srcVal [2];

  function automatic logic opWrites(input logic [3:0] op);
    return (op != 4'h0) && (op <= 4'hC);
  endfunction

  assign s2Adv       = !s2ValidReg || !bus.wbHold;
  assign s1Adv       = !s1ValidReg || s2Adv;
  assign bus.idReady = s1Adv;
  assign s1Wr        = s1ValidReg && opWrites(s1OpReg);

  assign srcIdx[0] = bus.idRn;
  assign srcIdx[1] = bus.idRm;
  assign srcRf[0]  = bus.idValA;
  assign srcRf[1]  = bus.idValB;

  // The S1 result is still combinational on shResult, so it outranks S2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gBypass
      assign srcVal[gi] =
        (s1Wr && (s1RnReg == srcIdx[gi]))                       ? bus.shResult :
        (s2ValidReg && s2WrReg && (s2RnReg == srcIdx[gi]))      ? s2ValReg     :
                                                                  srcRf[gi];
    end
  endgenerate

  always_comb begin
    tNext = 1'b0;
    case (bus.idOp)
      4'h3, 4'h5: tNext = srcVal[0][31];
      4'h4, 4'h6: tNext = srcVal[0][0];
      default:    tNext = 1'b0;
    endcase
  end

  // Opcode to shifter mapping; reserved ops pass Rn through with shOp 0.
  always_comb begin
    bus.shValRs = 32'h0;
    bus.shOp    = 3'd0;
    bus.shValRt = 8'h0;
    if (s1ValidReg && (s1OpReg != 4'h0)) begin
      bus.shValRs = s1AReg;
      case (s1OpReg)
        4'h1: begin bus.shOp = 3'd1; bus.shValRt = s1BReg[7:0]; end
        4'h2: begin bus.shOp = 3'd2; bus.shValRt = s1BReg[7:0]; end
        4'h3: begin bus.shOp = 3'd1; bus.shValRt = 8'd1;  end
        4'h4: begin bus.shOp = 3'd3; bus.shValRt = 8'd1;  end
        4'h5: begin bus.shOp = 3'd2; bus.shValRt = 8'd1;  end
        4'h6: begin bus.shOp = 3'd4; bus.shValRt = 8'd1;  end
        4'h7: begin bus.shOp = 3'd1; bus.shValRt = 8'd2;  end
        4'h8: begin bus.shOp = 3'd3; bus.shValRt = 8'd2;  end
        4'h9: begin bus.shOp = 3'd1; bus.shValRt = 8'd8;  end
        4'hA: begin bus.shOp = 3'd3; bus.shValRt = 8'd8;  end
        4'hB: begin bus.shOp = 3'd1; bus.shValRt = 8'd16; end
        4'hC: begin bus.shOp = 3'd3; bus.shValRt = 8'd16; end
        default: begin bus.shOp = 3'd0; bus.shValRt = 8'd0; end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1ValidReg   <= 1'b0;
      s1OpReg      <= 4'h0;
      s1RnReg      <= 5'd0;
      s1AReg       <= 32'h0;
      s1BReg       <= 32'h0;
      s1TReg       <= 1'b0;
      s2ValidReg   <= 1'b0;
      s2WrReg      <= 1'b0;
      s2RnReg      <= 5'd0;
      s2ValReg     <= 32'h0;
      s2SetTReg    <= 1'b0;
      s2TReg       <= 1'b0;
      s2IllegalReg <= 1'b0;
    end else begin
      if (s1Adv) begin
        s1ValidReg <= bus.idValid;
        s1OpReg    <= bus.idOp;
        s1RnReg    <= bus.idRn;
        s1AReg     <= srcVal[0];
        s1BReg     <= srcVal[1];
        s1TReg     <= tNext;
      end
      // NOPs vanish here; everything else, reserved ops included, retires.
      if (s2Adv) begin
        s2ValidReg   <= s1ValidReg && (s1OpReg != 4'h0);
        s2WrReg      <= opWrites(s1OpReg);
        s2RnReg      <= s1RnReg;
        s2ValReg     <= bus.shResult;
        s2SetTReg    <= (s1OpReg >= 4'h3) && (s1OpReg <= 4'h6);
        s2TReg       <= s1TReg;
        s2IllegalReg <= s1OpReg >= 4'hD;
      end
    end
  end

  assign bus.wbValid   = s2ValidReg;
  assign bus.wbRn      = s2RnReg;
  assign bus.wbVal     = s2ValReg;
  assign bus.wbSetT    = s2SetTReg;
  assign bus.wbT       = s2TReg;
  assign bus.wbIllegal = s2ValidReg && s2IllegalReg && !bus.wbHold;

endmodule

// File: tb/tb_ex_shad_pipe.sv
// Scoreboard bench for ex_shad_pipe: directed shift instructions, a behavioural
// shifter on the shifter port, and a monitor checking every retired result.
module tb_ex_shad_pipe;

  typedef struct {
    logic [4:0]  rn;
    logic [31:0] val;
    logic        setT;
    logic        t;
    logic        illegal;
  } expT;

  logic clock;
  logic reset;
  int   nChecks;
  int   nFail;
  bit   ignoreOut;
  expT  sbQ[$];

  ex_shad_pipe_if bus ();

  ex_shad_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shifter behaviour: bit 7 of valRt selects a right shift by 32-count.
  function automatic logic [31:0] shiftModel(input logic [2:0] op,
                                             input logic [31:0] rs,
                                             input logic [7:0] rt);
    logic [63:0] wide;
    int          n;
    n = 32 - int'(rt[4:0]);
    case (op)
      3'd1: begin
        if (rt[7]) begin
          wide = {32'h0, rs} >> n;
          return wide[31:0];
        end
        return rs << rt[4:0];
      end
      3'd2: begin
        if (rt[7]) begin
          wide = $signed({{32{rs[31]}}, rs}) >>> n;
          return wide[31:0];
        end
        return rs << rt[4:0];
      end
      3'd3: return rs >> rt[5:0];
      3'd4: begin
        wide = $signed({{32{rs[31]}}, rs}) >>> rt[5:0];
        return wide[31:0];
      end
      default: return rs;
    endcase
  endfunction

  always_comb bus.shResult = shiftModel(bus.shOp, bus.shValRs, bus.shValRt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: the head entry must be presented while held and popped at retire.
  always @(negedge clock) begin
    if (!reset && !ignoreOut) begin
      if (bus.wbValid) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpected_wb: got rn %0d val %h, expected nothing", bus.wbRn, bus.wbVal);
        end else begin
          check("wbRn", 32'(bus.wbRn), 32'(sbQ[0].rn));
          check("wbVal", bus.wbVal, sbQ[0].val);
          check("wbSetT", 32'(bus.wbSetT), 32'(sbQ[0].setT));
          check("wbT", 32'(bus.wbT), 32'(sbQ[0].t));
          check("wbIllegal", 32'(bus.wbIllegal), 32'(sbQ[0].illegal && !bus.wbHold));
          if (!bus.wbHold) begin
            $display("retire rn=%0d val=%h setT=%0d t=%0d illegal=%0d",
                     bus.wbRn, bus.wbVal, bus.wbSetT, bus.wbT, bus.wbIllegal);
            void'(sbQ.pop_front());
          end
        end
      end else begin
        check("wbIllegal_idle", 32'(bus.wbIllegal), 32'h0);
      end
    end
  end

  // Presents one instruction, waits for acceptance, then leaves decode idle.
  task automatic issue(input logic [3:0] op, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] expVal, input bit expSetT, input bit expT);
    expT e;
    bit  accepted;
    bus.idValid = 1'b1;
    bus.idOp    = op;
    bus.idRn    = rn;
    bus.idRm    = rm;
    bus.idValA  = a;
    bus.idValB  = b;
    accepted    = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (bus.idReady) accepted = 1'b1;
    end
    if (!accepted) begin
      nChecks++;
      nFail++;
      $display("FAIL issue_timeout: got idReady 0 for op %h, expected 1", op);
      bus.idValid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.idValid = 1'b0;
    $display("issue op=%h rn=%0d rm=%0d a=%h b=%h", op, rn, rm, a, b);
    if (push && op != 4'h0) begin
      e.rn      = rn;
      e.val     = expVal;
      e.setT    = expSetT;
      e.t       = expT;
      e.illegal = op >= 4'hD;
      sbQ.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nChecks     = 0;
    nFail       = 0;
    ignoreOut   = 1'b0;
    reset       = 1'b1;
    bus.idValid = 1'b0;
    bus.idOp    = 4'h0;
    bus.idRn    = 5'd0;
    bus.idRm    = 5'd0;
    bus.idValA  = 32'h0;
    bus.idValB  = 32'h0;
    bus.wbHold  = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_idReady", 32'(bus.idReady), 32'h1);
    check("rst_wbValid", 32'(bus.wbValid), 32'h0);
    check("rst_wbRn", 32'(bus.wbRn), 32'h0);
    check("rst_wbVal", bus.wbVal, 32'h0);
    check("rst_wbSetT", 32'(bus.wbSetT), 32'h0);
    check("rst_wbT", 32'(bus.wbT), 32'h0);
    check("rst_wbIllegal", 32'(bus.wbIllegal), 32'h0);

    // SHLL with latency: in S1 for the first cycle, wbValid in the second.
    @(posedge clock); #1;
    issue(4'h3, 5'd1, 5'd0, 32'h80000001, 32'h0, 1, 32'h00000002, 1, 1);
    @(negedge clock);
    check("lat_s1_wbValid", 32'(bus.wbValid), 32'h0);
    @(negedge clock);
    check("lat_s2_wbValid", 32'(bus.wbValid), 32'h1);
    idle(3);

    issue(4'h6, 5'd2, 5'd0, 32'h80000000, 32'h0, 1, 32'hC0000000, 1, 0);
    issue(4'h4, 5'd4, 5'd0, 32'h80000000, 32'h0, 1, 32'h40000000, 1, 0);
    idle(3);

    issue(4'h2, 5'd5, 5'd6, 32'h80000000, 32'hFFFFFFE0, 1, 32'hFFFFFFFF, 0, 0);
    issue(4'h1, 5'd7, 5'd6, 32'h80000000, 32'hFFFFFFE0, 1, 32'h00000000, 0, 0);
    issue(4'h1, 5'd8, 5'd9, 32'h00000001, 32'h00000004, 1, 32'h00000010, 0, 0);
    idle(3);

    // Dependent pair: S1 bypass, then S2 bypass with a NOP in between.
    issue(4'h9, 5'd3, 5'd0, 32'h000000AB, 32'h0, 1, 32'h0000AB00, 0, 0);
    issue(4'h8, 5'd3, 5'd0, 32'h000000AB, 32'h0, 1, 32'h00002AC0, 0, 0);
    idle(3);
    issue(4'h9, 5'd3, 5'd0, 32'h000000AB, 32'h0, 1, 32'h0000AB00, 0, 0);
    issue(4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1, 32'h0, 0, 0);
    issue(4'h8, 5'd3, 5'd0, 32'h000000AB, 32'h0, 1, 32'h00002AC0, 0, 0);
    idle(3);

    // Writeback stall for three cycles under back-to-back issue.
    bus.wbHold = 1'b1;
    fork
      begin
        repeat (3) @(posedge clock);
        #1 bus.wbHold = 1'b0;
      end
    join_none
    issue(4'h7, 5'd10, 5'd0, 32'h1, 32'h0, 1, 32'h4, 0, 0);
    issue(4'h7, 5'd11, 5'd0, 32'h3, 32'h0, 1, 32'hC, 0, 0);
    @(negedge clock);
    check("hold_idReady", 32'(bus.idReady), 32'h0);
    issue(4'h7, 5'd12, 5'd0, 32'h5, 32'h0, 1, 32'h14, 0, 0);
    idle(4);

    // Reserved opcode writes nothing, so the follower reads its own A.
    issue(4'hE, 5'd9, 5'd0, 32'h00001234, 32'h0, 1, 32'h00001234, 0, 0);
    issue(4'h3, 5'd9, 5'd0, 32'h00000010, 32'h0, 1, 32'h00000020, 1, 0);
    idle(4);

    // Reset with both stages full discards everything in flight.
    ignoreOut  = 1'b1;
    bus.wbHold = 1'b1;
    issue(4'h3, 5'd20, 5'd0, 32'h1, 32'h0, 0, 32'h0, 0, 0);
    issue(4'h3, 5'd21, 5'd0, 32'h2, 32'h0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset      = 1'b0;
    bus.wbHold = 1'b0;
    @(negedge clock);
    check("midrst_idReady", 32'(bus.idReady), 32'h1);
    check("midrst_wbVal", bus.wbVal, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("midrst_wbValid", 32'(bus.wbValid), 32'h0);
      @(negedge clock);
    end
    ignoreOut = 1'b0;

    for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(posedge clock);
    check("scoreboard_empty", 32'(sbQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ex_shad_pipe.md
# ex_shad_pipe

Two-stage issue/writeback pipeline wrapping the 32-bit SHAD/SHLD combinational shifter in the execute path. Accepts decoded shift instructions from decode with a valid/ready handshake and maps each opcode onto the shifter's `shOp`/`valRt` encoding. Registers the shifter result with the destination register index, computes the T bit for single-bit shifts, and bypasses in-flight results to dependent back-to-back instructions.

## Interface
Parameters: none.
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- `idValid`  in  1  decode presents an instruction
- `idReady`  out  1  stage can accept this cycle
- `idOp`  in  4  operation code (see Operation)
- `idRn`  in  5  destination/source register index
- `idRm`  in  5  shift-amount register index (SHLD/SHAD only)
- `idValA`  in  32  register-file value of Rn
- `idValB`  in  32  register-file value of Rm
- `shValRs`  out  32  to shifter `valRs`
- `shValRt`  out  8  to shifter `valRt`
- `shOp`  out  3  to shifter `shOp`
- `shResult`  in  32  from shifter `valRn` (combinational)
- `wbHold`  in  1  writeback stalled; S2 must hold
- `wbValid`  out  1  S2 holds a result to retire
- `wbRn`  out  5  destination index
- `wbVal`  out  32  result
- `wbSetT`  out  1  result updates T
- `wbT`  out  1  new T value
- `wbIllegal`  out  1  one-cycle pulse: reserved opcode retired

## Operation
- Opcodes (`shValRs`/`shOp`/`shValRt`/T):
  - 0 NOP: no writeback
  - 1 SHLD: Rn / 1 / Rm[7:0]
  - 2 SHAD: Rn / 2 / Rm[7:0]
  - 3 SHLL: 1/1, T=Rn[31]
  - 4 SHLR: 3/1, T=Rn[0]
  - 5 SHAL: 2/1, T=Rn[31]
  - 6 SHAR: 4/1, T=Rn[0]
  - 7 SHLL2: 1/2
  - 8 SHLR2: 3/2
  - 9 SHLL8: 1/8
  - A SHLR8: 3/8
  - B SHLL16: 1/16
  - C SHLR16: 3/16
  - D–F reserved: pass through, no register write, `wbIllegal` at retire
- `wbSetT`=1 only for opcodes 3–6.
- Shift-amount semantics (bit 7 = direction, bits 4:0 = count; 0x80|0 right-shift gives 0 for SHLD, sign fill for SHAD) belong to the shifter. This stage passes `Rm[7:0]` unmodified.
- S1 register holds: valid, op, Rn, operand A, operand B (after bypass), precomputed T.
- Shifter inputs are driven from S1 only. When S1 is empty: `shOp`=0, `shValRs`=0, `shValRt`=0.
- S2 register holds: valid, Rn, `shResult`, setT, T, illegal. The NOP and reserved-op write-enable is carried as a flag; `wbValid` is asserted for every non-NOP op. NOPs are dropped at S1→S2.
- Bypass is applied independently to A (match `idRn`) and B (match `idRm`):
  - If S1 is valid, writes a register, and S1.Rn matches: use `shResult` (highest priority).
  - Else if S2 is valid, writes a register, and S2.Rn matches: use `wbVal`.
  - Else use the register-file value.
- Advance:
  - `s2Adv` = !S2.valid | !wbHold
  - `s1Adv` = !S1.valid | s2Adv
  - `idReady` = `s1Adv`

## Timing
- Reset: S1/S2 valid=0; `wbValid`=0, `wbRn`=0, `wbVal`=0, `wbSetT`=0, `wbT`=0, `wbIllegal`=0; `idReady`=1 in the cycle after reset.
- A reset asserted mid-operation discards all in-flight instructions. No writeback occurs after the reset edge.
- Latency: accepted at edge E0 → in S1 during E0..E1 → `wbValid` from E1 when unstalled. Two cycles from accept to retire.
- Throughput: one instruction per cycle while `wbHold`=0.
- Retire: the instruction retires at the edge where `wbValid`&`!wbHold`. `wbIllegal` is high only in the cycle before that edge, for reserved ops.
- `wbHold`=1:
  - S2 holds all outputs stable.
  - S1 fills, then holds.
  - `idReady` drops in the cycle S1 is full and S2 is held.
  - No loss, duplication or reordering.
- Accept and retire may occur on the same edge. Bypass then uses the S2/S1 contents visible before that edge.
- `idValid`=1 with `idReady`=0: decode holds its inputs. Inputs are not sampled.

## Test plan
- SHLL, Rn=0x80000001 → `wbVal`=0x00000002, `wbSetT`=1, `wbT`=1; `wbValid` exactly 2 cycles after accept.
- SHAR, Rn=0x80000000 → `wbVal`=0xC0000000, `wbT`=0. SHLR on the same value → 0x40000000, `wbT`=0.
- SHAD, Rm=0xFFFFFFE0, Rn=0x80000000 → 0xFFFFFFFF. SHLD with the same operands → 0x00000000. SHLD with Rm=0x00000004, Rn=0x1 → 0x10.
- SHLL8 r3 (A=0x000000AB) followed next cycle by SHLR2 r3 with stale A=0x000000AB → second result 0x00002AC0 via S1 bypass. Insert one NOP between them → same result via S2 bypass.
- `wbHold` high 3 cycles while issuing SHLL2 (0x1), SHLL2 (0x3), SHLL2 (0x5) back-to-back → `idReady` low while S1 and S2 are both full; results retire in order: 0x4, 0xC, 0x14.
- Opcode 0xE → `wbIllegal` high for one cycle at retire, no register write. Assert `reset` with S1 and S2 both full → no `wbValid` after reset; `idReady`=1.
